// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide busy timer.
package pipe_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the multi-cycle mult/div unit: busy for exactly N cycles after the
// edge that samples a launch.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A launch while busy cannot reach here in a legal pipeline; it is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    cnt_d   = md_is_div ? DIV_LD : MULT_LD;
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: Tuse/Tnew data-hazard detection plus mult/div
// occupancy, driving PC/IF-ID enables, ID/EX bubble insert and a stall counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             D_rs,
    input  logic [4:0]             D_rt,
    input  logic [1:0]             D_tuse_rs,
    input  logic [1:0]             D_tuse_rt,
    input  logic                   D_is_md,
    input  logic [4:0]             E_wreg,
    input  logic [1:0]             E_tnew,
    input  logic [4:0]             M_wreg,
    input  logic [1:0]             M_tnew,
    input  logic                   E_md_start,
    input  logic                   E_md_is_div,
    output logic                   PC_En,
    output logic                   FD_En,
    output logic                   DE_Clr,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic stall_rs, stall_rt, stall_md, stall;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Register 0 is hardwired, so it never carries a dependency.
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((src == E_wreg) && (E_tnew > tuse)) ||
                ((src == M_wreg) && (M_tnew > tuse)));
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk       (clk),
        .rst       (rst),
        .md_start  (E_md_start),
        .md_is_div (E_md_is_div),
        .md_busy   (md_busy)
    );

    assign stall_rs = src_hazard(D_rs, D_tuse_rs);
    assign stall_rt = src_hazard(D_rt, D_tuse_rt);
    // The launch cycle itself blocks too: the unit is not yet busy but will be.
    assign stall_md = D_is_md && (md_busy || E_md_start);
    assign stall    = stall_rs | stall_rt | stall_md;

    assign PC_En  = ~stall;
    assign FD_En  = ~stall;
    assign DE_Clr = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int N_MULT  = 5;
    localparam int N_DIV   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    D_rs = '0, D_rt = '0, E_wreg = '0, M_wreg = '0;
    logic [1:0]    D_tuse_rs = '0, D_tuse_rt = '0, E_tnew = '0, M_tnew = '0;
    logic          D_is_md = 1'b0, E_md_start = 1'b0, E_md_is_div = 1'b0;
    logic          PC_En, FD_En, DE_Clr, md_busy;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .MULT_CYCLES (N_MULT),
        .DIV_CYCLES  (N_DIV),
        .STALL_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_tuse_rs   (D_tuse_rs),
        .D_tuse_rt   (D_tuse_rt),
        .D_is_md     (D_is_md),
        .E_wreg      (E_wreg),
        .E_tnew      (E_tnew),
        .M_wreg      (M_wreg),
        .M_tnew      (M_tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .PC_En       (PC_En),
        .FD_En       (FD_En),
        .DE_Clr      (DE_Clr),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs, rt, tuse_rs, tuse_rt, is_md, ew, et, mw, mt, start, is_div;
    } stim_t;

    typedef struct {
        int stall, busy, cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: remaining busy cycles of the MD unit and stall count.
    int m_rem = 0;
    int m_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int dep(int src, int tuse, int ew, int et, int mw, int mt);
        if (src == 0 || tuse == 3) return 0;
        if (src == ew && et > tuse) return 1;
        if (src == mw && mt > tuse) return 1;
        return 0;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s = '{default: 0};
        s.tuse_rs = 3;
        s.tuse_rt = 3;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        D_rs        = 5'(s.rs);
        D_rt        = 5'(s.rt);
        D_tuse_rs   = 2'(s.tuse_rs);
        D_tuse_rt   = 2'(s.tuse_rt);
        D_is_md     = 1'(s.is_md);
        E_wreg      = 5'(s.ew);
        E_tnew      = 2'(s.et);
        M_wreg      = 5'(s.mw);
        M_tnew      = 2'(s.mt);
        E_md_start  = 1'(s.start);
        E_md_is_div = 1'(s.is_div);
    endtask

    // One pipeline cycle: drive, predict this cycle's outputs, then move the
    // model across the coming edge.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.busy  = (m_rem > 0);
        e.cnt   = m_cnt;
        e.stall = dep(s.rs, s.tuse_rs, s.ew, s.et, s.mw, s.mt) |
                  dep(s.rt, s.tuse_rt, s.ew, s.et, s.mw, s.mt) |
                  ((s.is_md != 0 && (m_rem > 0 || s.start != 0)) ? 1 : 0);
        q.push_back(e);
        if (e.stall != 0 && m_cnt < CNT_MAX) m_cnt++;
        if (m_rem > 0) m_rem--;
        else if (s.start != 0) m_rem = s.is_div ? N_DIV : N_MULT;
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        apply(idle_stim());
        rst = 1'b1;
        #1;
        check("rst_md_busy_async", int'(md_busy), 0);
        check("rst_stall_cnt_async", int'(stall_cnt), 0);
        m_rem = 0;
        m_cnt = 0;
        e = '{stall: 0, busy: 0, cnt: 0};
        q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: outputs are combinational and valid every cycle; sample at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (E_md_start && !rst) check("md_start_while_busy", int'(md_busy), 0);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("PC_En",     int'(PC_En),     1 - e.stall);
                check("FD_En",     int'(FD_En),     1 - e.stall);
                check("DE_Clr",    int'(DE_Clr),    e.stall);
                check("md_busy",   int'(md_busy),   e.busy);
                check("stall_cnt", int'(stall_cnt), e.cnt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got %0t, expected less", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        do_reset();

        // Load-use then resolved via MEM forwarding.
        s = idle_stim(); s.ew = 8; s.et = 2; s.rs = 8; s.tuse_rs = 1;
        step(s);
        s = idle_stim(); s.mw = 8; s.mt = 1; s.rs = 8; s.tuse_rs = 1;
        step(s);
        step(idle_stim());

        // Register 0 and an unread operand never stall.
        s = idle_stim(); s.rs = 0; s.tuse_rs = 0; s.ew = 0; s.et = 2;
        step(s);
        s = idle_stim(); s.rt = 9; s.tuse_rt = 3; s.ew = 9; s.et = 2; s.mw = 9; s.mt = 2;
        step(s);

        // mult followed by mfhi held in decode.
        s = idle_stim(); s.start = 1; s.is_div = 0; s.is_md = 1;
        step(s);
        s = idle_stim(); s.is_md = 1;
        repeat (N_MULT + 2) step(s);

        // div, reset during the fourth busy cycle.
        s = idle_stim(); s.start = 1; s.is_div = 1; s.is_md = 1;
        step(s);
        s = idle_stim(); s.is_md = 1;
        repeat (3) step(s);
        do_reset();

        // Full div busy window.
        s = idle_stim(); s.start = 1; s.is_div = 1;
        step(s);
        s = idle_stim(); s.is_md = 1;
        repeat (N_DIV + 2) step(s);

        // Randomised traffic; launches only when the unit is free.
        for (int i = 0; i < 400; i++) begin
            s.rs      = $urandom_range(0, 3);
            s.rt      = $urandom_range(0, 3);
            s.tuse_rs = $urandom_range(0, 3);
            s.tuse_rt = $urandom_range(0, 3);
            s.ew      = $urandom_range(0, 3);
            s.et      = $urandom_range(0, 3);
            s.mw      = $urandom_range(0, 3);
            s.mt      = $urandom_range(0, 3);
            s.is_md   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            s.is_div  = $urandom_range(0, 1);
            s.start   = (m_rem == 0 && $urandom_range(0, 7) == 0) ? 1 : 0;
            step(s);
        end

        // Continuous stall drives the counter into saturation.
        s = idle_stim(); s.ew = 5; s.et = 2; s.rt = 5; s.tuse_rt = 0;
        repeat (CNT_MAX + 20) step(s);
        @(negedge clk);
        #1;
        check("stall_cnt_saturated", int'(stall_cnt), CNT_MAX);

        step(idle_stim());
        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
